// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reconfiguration sequencer.
//   pll_state_t : sequencer FSM states
//   sel_code_t  : 6-bit PLL divider select code (IDSEL/FBDSEL/ODSEL)
//   cnt_w()     : width of a counter that must hold values 0..limit
//   LOSS_CNT_W  : width of the saturating lock-loss counter
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN,
        ST_FAIL
    } pll_state_t;

    typedef logic [5:0] sel_code_t;

    localparam int unsigned LOSS_CNT_W = 8;

    function automatic int unsigned cnt_w(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Lock qualifier: 2-FF synchroniser on the asynchronous PLL lock plus a
// counter of consecutive synchronised-high cycles.
//   clk, rst_n  : clock, asynchronous active-low reset
//   lock_async  : raw PLL lock (asynchronous to clk)
//   clear       : forces the consecutive-high count to zero
//   lock_s      : synchronised lock
//   stable_done : high on the STABLE_CYC-th consecutive lock_s=1 cycle
module pll_lock_filter
    import pll_seq_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_async,
    input  logic clear,
    output logic lock_s,
    output logic stable_done
);

    localparam int unsigned W = cnt_w(STABLE_CYC);
    localparam logic [W-1:0] LAST = W'(STABLE_CYC - 1);

    logic         lock_meta;
    logic [W-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= lock_async;
            lock_s    <= lock_meta;
        end
    end

    // run_cnt holds the number of earlier consecutive high cycles, so the
    // current cycle completes the run when run_cnt == STABLE_CYC-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (clear || !lock_s) begin
            run_cnt <= '0;
        end else if (run_cnt != LAST) begin
            run_cnt <= run_cnt + W'(1);
        end
    end

    assign stable_done = lock_s && (run_cnt == LAST);

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL control sequencer on the free-running reference clock.
// Holds the PLL in reset, waits for a qualified lock (with timeout and
// retries), releases downstream resets in staggered order, supervises lock
// in RUN, and accepts runtime divider reconfiguration via valid/ready.
//   clk, rst_n                  : sole clock, asynchronous active-low reset
//   cfg_valid/cfg_ready         : reconfiguration handshake
//   cfg_idsel/fbdsel/odsel      : requested divider codes
//   pll_lock                    : raw PLL lock input
//   pll_reset                   : PLL reset, active high
//   pll_idsel/fbdsel/odsel      : registered divider codes to the PLL
//   rst_out_n                   : downstream active-low resets
//   locked, busy, err_timeout   : status
//   retry_cnt                   : failed attempts in the current sequence
//   lock_loss_cnt               : saturating count of lock losses in RUN
module pll_reconfig_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_RST          = 4,
    parameter int unsigned RST_HOLD_CYC     = 16,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned STAGGER_CYC      = 16,
    parameter sel_code_t   DEF_IDSEL        = 6'd0,
    parameter sel_code_t   DEF_FBDSEL       = 6'd0,
    parameter sel_code_t   DEF_ODSEL        = 6'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [5:0]                    cfg_idsel,
    input  logic [5:0]                    cfg_fbdsel,
    input  logic [5:0]                    cfg_odsel,
    input  logic                          pll_lock,
    output logic                          pll_reset,
    output logic [5:0]                    pll_idsel,
    output logic [5:0]                    pll_fbdsel,
    output logic [5:0]                    pll_odsel,
    output logic [NUM_RST-1:0]            rst_out_n,
    output logic                          locked,
    output logic                          busy,
    output logic                          err_timeout,
    output logic [cnt_w(MAX_RETRY)-1:0]   retry_cnt,
    output logic [LOSS_CNT_W-1:0]         lock_loss_cnt
);

    localparam int unsigned REL_LAST = (NUM_RST - 1) * STAGGER_CYC;
    localparam int unsigned MAX_A    = (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ? RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned CNT_MAX  = (MAX_A > REL_LAST) ? MAX_A : REL_LAST;
    localparam int unsigned CW       = cnt_w(CNT_MAX);
    localparam int unsigned RW       = cnt_w(MAX_RETRY);

    pll_state_t              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]           retry_d;
    logic                    err_d;
    logic [LOSS_CNT_W-1:0]   loss_d;
    sel_code_t               idsel_d, fbdsel_d, odsel_d;
    logic                    lock_s, stable_done, filt_clear, hs;

    pll_lock_filter #(
        .STABLE_CYC (LOCK_STABLE_CYC)
    ) u_lock_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .lock_async  (pll_lock),
        .clear       (filt_clear),
        .lock_s      (lock_s),
        .stable_done (stable_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            retry_cnt     <= '0;
            err_timeout   <= 1'b0;
            lock_loss_cnt <= '0;
            pll_idsel     <= DEF_IDSEL;
            pll_fbdsel    <= DEF_FBDSEL;
            pll_odsel     <= DEF_ODSEL;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_cnt     <= retry_d;
            err_timeout   <= err_d;
            lock_loss_cnt <= loss_d;
            pll_idsel     <= idsel_d;
            pll_fbdsel    <= fbdsel_d;
            pll_odsel     <= odsel_d;
        end
    end

    assign cfg_ready = (state_q == ST_RUN) || (state_q == ST_FAIL);
    assign hs        = cfg_valid && cfg_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        retry_d    = retry_cnt;
        err_d      = err_timeout;
        loss_d     = lock_loss_cnt;
        idsel_d    = pll_idsel;
        fbdsel_d   = pll_fbdsel;
        odsel_d    = pll_odsel;
        filt_clear = 1'b1;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == CW'(RST_HOLD_CYC - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            // cnt_q is the shared lock-window timer here. A completed
            // stable run wins over the timeout; the timeout wins over a
            // fresh lock, so every attempt ends on a fixed window cycle.
            ST_WAIT_LOCK, ST_STABLE: begin
                filt_clear = 1'b0;
                if ((state_q == ST_STABLE) && stable_done) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT_CYC - 1)) begin
                    cnt_d = '0;
                    if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_d = retry_cnt + RW'(1);
                        state_d = ST_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FAIL;
                    end
                end else begin
                    state_d = lock_s ? ST_STABLE : ST_WAIT_LOCK;
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(REL_LAST)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    if (lock_loss_cnt != '1) loss_d = lock_loss_cnt + LOSS_CNT_W'(1);
                    retry_d = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
        // A handshake overrides a simultaneous lock loss; both lead to the
        // same single HOLD entry, and the loss is still counted above.
        if (hs) begin
            idsel_d  = cfg_idsel;
            fbdsel_d = cfg_fbdsel;
            odsel_d  = cfg_odsel;
            err_d    = 1'b0;
            retry_d  = '0;
            state_d  = ST_HOLD;
            cnt_d    = '0;
        end
    end

    assign pll_reset = (state_q == ST_HOLD) || (state_q == ST_FAIL);
    assign busy      = !cfg_ready;
    assign locked    = (state_q == ST_RUN) && lock_s;

    // Gated with lock_s so a lock drop pulls every reset low in that cycle.
    always_comb begin
        rst_out_n = '0;
        for (int unsigned i = 0; i < NUM_RST; i++) begin
            if (state_q == ST_RELEASE)
                rst_out_n[i] = lock_s && (cnt_q >= CW'(i * STAGGER_CYC));
            else if (state_q == ST_RUN)
                rst_out_n[i] = lock_s;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: a phase/elapsed-time reference
// model compared every cycle, plus directed scenarios with literal timing.
module tb_pll_reconfig_seq;

    localparam int P_NUM_RST = 4;
    localparam int P_HOLD    = 4;
    localparam int P_STABLE  = 8;
    localparam int P_TMO     = 32;
    localparam int P_MAXR    = 2;
    localparam int P_STAG    = 3;
    localparam logic [5:0] P_DID = 6'd7;
    localparam logic [5:0] P_DFB = 6'd21;
    localparam logic [5:0] P_DOD = 6'd42;

    logic       clk = 1'b0;
    logic       rst_n, cfg_valid, cfg_ready, pll_lock, pll_reset;
    logic       locked, busy, err_timeout;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel, pll_idsel, pll_fbdsel, pll_odsel;
    logic [P_NUM_RST-1:0] rst_out_n;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    pll_reconfig_seq #(
        .NUM_RST(P_NUM_RST), .RST_HOLD_CYC(P_HOLD), .LOCK_STABLE_CYC(P_STABLE),
        .LOCK_TIMEOUT_CYC(P_TMO), .MAX_RETRY(P_MAXR), .STAGGER_CYC(P_STAG),
        .DEF_IDSEL(P_DID), .DEF_FBDSEL(P_DFB), .DEF_ODSEL(P_DOD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
        .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_idsel(pll_idsel),
        .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .rst_out_n(rst_out_n),
        .locked(locked), .busy(busy), .err_timeout(err_timeout),
        .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase + elapsed time; lock qualification is a plain
    // run-length of the synchronised lock over the whole lock window.
    localparam int M_HOLD = 0, M_WAIT = 1, M_REL = 2, M_RUN = 3, M_FAIL = 4;
    int         m_mode, m_t, m_run, m_retry, m_loss;
    bit         m_err, m_s1, m_lks, m_acc, m_hs;
    logic [5:0] m_id, m_fb, m_od;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_HOLD; m_t = 0; m_run = 0; m_retry = 0; m_loss = 0;
            m_err = 0; m_s1 = 0; m_lks = 0; m_acc = 0;
            m_id = P_DID; m_fb = P_DFB; m_od = P_DOD;
        end else begin
            m_hs  = cfg_valid && (m_mode == M_RUN || m_mode == M_FAIL);
            m_acc = m_hs;
            case (m_mode)
                M_HOLD: begin
                    m_t++;
                    if (m_t == P_HOLD) begin m_mode = M_WAIT; m_t = 0; m_run = 0; end
                end
                M_WAIT: begin
                    m_t++;
                    m_run = m_lks ? m_run + 1 : 0;
                    if (m_run == P_STABLE) begin
                        m_mode = M_REL; m_t = 0;
                    end else if (m_t == P_TMO) begin
                        if (m_retry < P_MAXR) begin m_retry++; m_mode = M_HOLD; m_t = 0; end
                        else begin m_err = 1; m_mode = M_FAIL; end
                    end
                end
                M_REL: begin
                    if (!m_lks) begin m_mode = M_HOLD; m_t = 0; end
                    else begin
                        m_t++;
                        if (m_t == (P_NUM_RST - 1) * P_STAG + 1) m_mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (!m_lks) begin
                        if (m_loss < 255) m_loss++;
                        m_retry = 0; m_mode = M_HOLD; m_t = 0;
                    end
                end
                default: ;
            endcase
            if (m_hs) begin
                m_id = cfg_idsel; m_fb = cfg_fbdsel; m_od = cfg_odsel;
                m_err = 0; m_retry = 0; m_mode = M_HOLD; m_t = 0;
            end
            m_lks = m_s1;
            m_s1  = pll_lock;
        end
    end

    logic [P_NUM_RST-1:0] e_rst;
    bit e_run, e_fail;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_run  = (m_mode == M_RUN);
            e_fail = (m_mode == M_FAIL);
            e_rst  = '0;
            for (int i = 0; i < P_NUM_RST; i++) begin
                if (m_mode == M_REL) e_rst[i] = m_lks && (m_t >= i * P_STAG);
                else if (e_run)      e_rst[i] = m_lks;
            end
            chk("ctl", {pll_reset, rst_out_n, locked, busy, cfg_ready},
                {(m_mode == M_HOLD) || e_fail, e_rst, e_run && m_lks, !(e_run || e_fail), e_run || e_fail});
            chk("status", {err_timeout, retry_cnt, lock_loss_cnt}, {m_err, 2'(m_retry), 8'(m_loss)});
            chk("sel", {pll_idsel, pll_fbdsel, pll_odsel}, {m_id, m_fb, m_od});
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_reset"}, pll_reset, 1);
        chk({tag, "_rst_out_n"}, rst_out_n, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_cfg_ready"}, cfg_ready, 0);
        chk({tag, "_status"}, {err_timeout, retry_cnt, lock_loss_cnt}, 0);
        chk({tag, "_sel"}, {pll_idsel, pll_fbdsel, pll_odsel}, {6'd7, 6'd21, 6'd42});
    endtask

    task automatic wait_locked(input string name, input int limit);
        int k = 0;
        while (!locked && k < limit) begin @(negedge clk); k++; end
        chk(name, locked, 1);
    endtask

    int k, t1, t2, seg, bad;

    initial begin
        rst_n = 0; pll_lock = 0; cfg_valid = 0;
        cfg_idsel = 0; cfg_fbdsel = 0; cfg_odsel = 0;
        repeat (2) @(posedge clk);
        cmp_en = 1;
        @(negedge clk);
        chk_reset_vals("por");

        // Cold start: hold length, then lock 10 cycles after pll_reset falls
        rst_n = 1;
        k = 0;
        while (pll_reset && k < 100) begin k++; @(negedge clk); end
        chk("hold_len", k, 4);
        repeat (10) @(negedge clk);
        pll_lock = 1;
        k = 0;
        while (rst_out_n == 0 && k < 200) begin @(negedge clk); k++; end
        chk("rel0_delay", k, 10);
        chk("rel0", rst_out_n, 4'b0001);
        repeat (3) @(negedge clk); chk("rel1", rst_out_n, 4'b0011);
        repeat (3) @(negedge clk); chk("rel2", rst_out_n, 4'b0111);
        repeat (3) @(negedge clk); chk("rel3", rst_out_n, 4'b1111);
        chk("rel3_locked", locked, 0);
        @(negedge clk);
        chk("run_locked", locked, 1);
        chk("run_busy", busy, 0);
        chk("run_ready", cfg_ready, 1);

        // Lock loss in RUN
        repeat (5) @(negedge clk);
        pll_lock = 0;
        @(negedge clk); chk("drop_sync1", locked, 1);
        @(negedge clk); chk("drop_rst", rst_out_n, 0); chk("drop_locked", locked, 0);
        @(negedge clk); chk("loss_cnt", lock_loss_cnt, 1); chk("drop_hold", pll_reset, 1);

        // Rerun with a one-cycle glitch at stable count 5
        k = 0;
        while (pll_reset && k < 100) begin @(negedge clk); k++; end
        pll_lock = 1;
        k = 0;
        while (rst_out_n == 0 && k < 200) begin
            @(negedge clk); k++;
            if (k == 5) pll_lock = 0;
            if (k == 6) pll_lock = 1;
        end
        chk("glitch_delay", k, 16);
        chk("glitch_retry", retry_cnt, 0);
        wait_locked("glitch_relock", 100);

        // Reconfiguration in RUN
        repeat (3) @(negedge clk);
        chk("hs1_ready", cfg_ready, 1);
        cfg_valid = 1; cfg_idsel = 5; cfg_fbdsel = 9; cfg_odsel = 12;
        @(negedge clk);
        cfg_valid = 0;
        chk("hs1_reset", pll_reset, 1);
        chk("hs1_sel", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd5, 6'd9, 6'd12});
        k = 0; bad = 0;
        while (!locked && k < 200) begin
            if (!busy || cfg_ready) bad++;
            @(negedge clk); k++;
        end
        chk("hs1_relock_delay", k, 22);
        chk("hs1_busy_window", bad, 0);

        // Lock never asserts: retries then FAIL
        cfg_valid = 1; cfg_idsel = 1; cfg_fbdsel = 2; cfg_odsel = 3; pll_lock = 0;
        @(negedge clk);
        cfg_valid = 0;
        k = 1; t1 = -1; t2 = -1;
        while (!err_timeout && k < 300) begin
            if (retry_cnt == 1 && t1 < 0) t1 = k;
            if (retry_cnt == 2 && t2 < 0) t2 = k;
            @(negedge clk); k++;
        end
        chk("retry1_at", t1, 37);
        chk("retry2_at", t2, 73);
        chk("fail_at", k, 109);
        repeat (20) @(negedge clk);
        chk("fail_state", {pll_reset, cfg_ready, err_timeout, retry_cnt, rst_out_n, locked},
            {1'b1, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0});

        // Recover from FAIL via handshake
        pll_lock = 1;
        cfg_valid = 1; cfg_idsel = 33; cfg_fbdsel = 20; cfg_odsel = 63;
        @(negedge clk);
        cfg_valid = 0;
        chk("fail_hs_clear", {err_timeout, retry_cnt}, 0);
        chk("fail_hs_sel", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd33, 6'd20, 6'd63});
        wait_locked("fail_recover", 200);

        // Reset asserted mid-RELEASE
        pll_lock = 0;
        repeat (3) @(negedge clk);
        pll_lock = 1;
        k = 0;
        while (rst_out_n != 4'b0011 && k < 300) begin @(negedge clk); k++; end
        chk("reach_release", rst_out_n, 4'b0011);
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Randomised lock behaviour and reconfiguration requests
        seg = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (seg == 0) begin
                pll_lock = ~pll_lock;
                if (pll_lock) seg = $urandom_range(5, 80);
                else seg = ($urandom_range(0, 7) == 0) ? 120 : $urandom_range(1, 45);
            end
            seg--;
            if (cfg_valid && m_acc) cfg_valid = 0;
            else if (!cfg_valid && $urandom_range(0, 39) == 0) begin
                cfg_valid  = 1;
                cfg_idsel  = 6'($urandom);
                cfg_fbdsel = 6'($urandom);
                cfg_odsel  = 6'($urandom);
            end
        end
        cfg_valid = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Parametrised PLL control sequencer that runs on the free-running PLL reference clock.
- Owns the PLL reset pin and the dynamic divider selects (IDSEL/FBDSEL/ODSEL), and supervises the lock signal.
- Qualifies lock, retries on timeout, and releases NUM_RST downstream resets in staggered order.
- Accepts runtime divider reconfiguration via a valid/ready handshake, enabling video-mode changes without a bitstream reload.

Parameters:
NUM_RST, 4, number of downstream active-low reset outputs (1..16)
RST_HOLD_CYC, 16, cycles pll_reset is held high per attempt (>=2)
LOCK_STABLE_CYC, 1024, consecutive cycles of synced lock required before release
LOCK_TIMEOUT_CYC, 65536, cycles allowed in lock wait before an attempt fails
MAX_RETRY, 3, failed attempts allowed after the first before FAIL
STAGGER_CYC, 16, cycles between successive rst_out_n releases
DEF_IDSEL, 6'd0, power-up IDSEL code
DEF_FBDSEL, 6'd0, power-up FBDSEL code
DEF_ODSEL, 6'd0, power-up ODSEL code

Ports:
clk  in  1  free-running PLL reference clock; sole clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  reconfiguration request
cfg_ready  out  1  request accepted when cfg_valid&&cfg_ready
cfg_idsel  in  6  new IDSEL code
cfg_fbdsel  in  6  new FBDSEL code
cfg_odsel  in  6  new ODSEL code
pll_lock  in  1  PLL lock, asynchronous to clk
pll_reset  out  1  PLL reset, active high
pll_idsel  out  6  registered IDSEL to PLL
pll_fbdsel  out  6  registered FBDSEL to PLL
pll_odsel  out  6  registered ODSEL to PLL
rst_out_n  out  NUM_RST  downstream resets, active low
locked  out  1  qualified lock, all resets released
busy  out  1  sequence in progress
err_timeout  out  1  sticky; retries exhausted
retry_cnt  out  clog2(MAX_RETRY+1)  failed attempts in current sequence
lock_loss_cnt  out  8  saturating count of lock losses while in RUN

Behaviour:
- Clock and reset: one clock domain only. Reset is asynchronous and active-low. pll_lock passes through a 2-FF synchroniser (lock_s) before any use.
- Reset values:
  - pll_reset=1, rst_out_n=0, locked=0, busy=1, cfg_ready=0.
  - err_timeout=0, retry_cnt=0, lock_loss_cnt=0.
  - Selects = DEF_*.
  - After rst_n deasserts, the FSM starts in HOLD with a fresh counter.
- FSM states: HOLD, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL.
- HOLD:
  - pll_reset=1 for exactly RST_HOLD_CYC cycles, all rst_out_n=0, then go to WAIT_LOCK.
  - Select outputs change only on entry to HOLD, never while pll_reset=0.
- WAIT_LOCK:
  - pll_reset=0; the timeout counter increments every cycle.
  - lock_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT_CYC:
    - retry_cnt<MAX_RETRY: retry_cnt++, go to HOLD.
    - Otherwise: err_timeout=1, go to FAIL.
- STABLE:
  - Counts consecutive lock_s=1 cycles; the timeout counter keeps running.
  - lock_s drops: clear the stable count, return to WAIT_LOCK.
  - Stable count reaches LOCK_STABLE_CYC: go to RELEASE.
  - A timeout reached in STABLE is handled as in WAIT_LOCK.
- RELEASE:
  - rst_out_n[0] goes to 1 on the first RELEASE cycle.
  - rst_out_n[i] goes to 1 exactly i*STAGGER_CYC cycles later.
  - One cycle after the last release, go to RUN.
  - lock_s drop during RELEASE: all rst_out_n=0 in the same cycle (combinational gating), go to HOLD.
- RUN:
  - locked=1, busy=0, cfg_ready=1.
  - lock_s drop: in the same cycle all rst_out_n=0 and locked=0; lock_loss_cnt++ (saturating at 255); retry_cnt=0; go to HOLD.
- FAIL:
  - pll_reset=1, all rst_out_n=0, cfg_ready=1.
  - Exit only via a cfg handshake or rst_n.
- Cfg handshake (accepted in RUN or FAIL):
  - Latch the cfg_* codes into pll_*sel on the cycle after the handshake.
  - Clear err_timeout and retry_cnt, drop locked, go to HOLD.
  - cfg_ready=0 in all other states; requests there are held off, not dropped.
- Simultaneous lock loss and handshake in RUN: the handshake is accepted, new codes are applied, and exactly one HOLD sequence runs. lock_loss_cnt still increments.
- Codes are passed to the PLL unmodified; the block does not encode or invert them.
- Counters are sized with clog2 of their limits.
- rst_n asserted mid-sequence returns every output to its reset value immediately, including selects to DEF_*.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum;
  - the 6-bit sel code typedef;
  - a clog2-based counter-width function;
  - the lock_loss_cnt width constant.
- Sub-module pll_lock_filter contains the 2-FF synchroniser plus the consecutive-high stability counter. It outputs lock_s and stable_done, and takes a clear input.

Test Plan (params: RST_HOLD_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2, STAGGER_CYC=3, NUM_RST=4):
- Cold start, with pll_lock rising 10 cycles after pll_reset falls:
  - pll_reset is high exactly 4 cycles.
  - rst_out_n goes 0001, 0011, 0111, 1111 at 3-cycle spacing, starting 8 cycles after lock_s rises.
  - locked=1 one cycle after 1111.
- Lock never asserts:
  - three attempts, each 4 cycles HOLD plus 32 cycles wait.
  - retry_cnt goes 1 then 2; then err_timeout=1, state FAIL, pll_reset=1, cfg_ready=1.
- Lock glitches low for 1 cycle at stable count 5:
  - the stable count restarts.
  - release occurs 8 full cycles after the glitch, with no retry increment.
- In RUN, pll_lock drops:
  - all rst_out_n=0 and locked=0 within 2 sync cycles.
  - lock_loss_cnt=1, then the full sequence reruns.
- In RUN, cfg handshake with idsel=5, fbdsel=9, odsel=12:
  - pll_*sel show 5/9/12 while pll_reset=1.
  - busy=1 until relock; cfg_ready=0 throughout.
- From FAIL, cfg handshake: err_timeout clears and the sequence completes normally. Then assert rst_n low mid-RELEASE: all outputs immediately return to reset values and selects return to DEF_*.
